// File: rtl/pwm_param_sched.sv
// PWM frame counter plus shadow/active parameter bank for the T/A1/A2/B1/B2 half-bridges.
// Shadow writes are committed atomically at the frame wrap; a latched fault zeroes all duties.
//
// state | meaning
// IDLE  | shadow set matches what was last committed, writes accepted
// DIRTY | shadow holds uncommitted writes, writes accepted
// ARMED | commit waits for the next counter wrap, writes blocked
// FAULT | duties forced to zero until software clears, writes blocked
module pwm_param_sched #(
  parameter int WIDTH = 13
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic             commit_req,
  output logic             commit_ack,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             fault_latched,
  output logic [WIDTH-1:0] cnt_out,
  output logic             frame_start,
  output logic [WIDTH-1:0] offset_T,
  output logic [WIDTH-1:0] duty_T,
  output logic [WIDTH-1:0] offset_A1,
  output logic [WIDTH-1:0] duty_A1,
  output logic [WIDTH-1:0] offset_A2,
  output logic [WIDTH-1:0] duty_A2,
  output logic [WIDTH-1:0] offset_B1,
  output logic [WIDTH-1:0] duty_B1,
  output logic [WIDTH-1:0] offset_B2,
  output logic [WIDTH-1:0] duty_B2
);

  localparam int NREG = 10;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DIRTY, ARMED, FAULT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q [NREG];
  logic [WIDTH-1:0] shadow_d [NREG];
  logic [WIDTH-1:0] active_q [NREG];
  logic [WIDTH-1:0] active_d [NREG];
  logic             wr_err_q, wr_err_d;
  logic             commit_ack_q, commit_ack_d;
  logic             wr_accept;
  logic             wrap;

  assign wr_ready  = (state_q == IDLE) || (state_q == DIRTY);
  assign wr_accept = wr_valid && wr_ready;
  assign wrap      = (cnt_q == CNT_MAX);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + WIDTH'(1);
    shadow_d     = shadow_q;
    active_d     = active_q;
    wr_err_d     = wr_accept && (wr_addr > 4'd9);
    commit_ack_d = 1'b0;

    if (wr_accept) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_addr == 4'(i)) shadow_d[i] = wr_data;
      end
    end

    if (fault_in) begin
      state_d = FAULT;
      // Odd slots are the duties; offsets keep their committed values.
      for (int i = 1; i < NREG; i += 2) active_d[i] = '0;
    end else begin
      case (state_q)
        IDLE, DIRTY: begin
          if (commit_req)     state_d = ARMED;
          else if (wr_accept) state_d = DIRTY;
        end
        ARMED: begin
          if (wrap) begin
            state_d      = IDLE;
            active_d     = shadow_q;
            commit_ack_d = 1'b1;
          end
        end
        FAULT: begin
          if (fault_clr) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      wr_err_q     <= 1'b0;
      commit_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      wr_err_q     <= wr_err_d;
      commit_ack_q <= commit_ack_d;
    end
  end

  assign wr_err        = wr_err_q;
  assign commit_ack    = commit_ack_q;
  assign fault_latched = (state_q == FAULT);
  assign cnt_out       = cnt_q;
  assign frame_start   = (cnt_q == '0);

  assign offset_T  = active_q[0];
  assign duty_T    = active_q[1];
  assign offset_A1 = active_q[2];
  assign duty_A1   = active_q[3];
  assign offset_A2 = active_q[4];
  assign duty_A2   = active_q[5];
  assign offset_B1 = active_q[6];
  assign duty_B1   = active_q[7];
  assign offset_B2 = active_q[8];
  assign duty_B2   = active_q[9];

endmodule
